// File: rtl/interp_x16.sv
// interp_x16 -- x16 linear interpolator for low-rate 8-bit samples.
//
// Accepted samples wait in a small FIFO. The control FSM primes a "prev" and
// a "next" endpoint, then produces 16 output samples per input sample. Each
// output is the straight-line value between the two endpoints. When the FIFO
// is empty at a segment boundary, the output holds the last endpoint and a
// sticky underrun flag is set.
//
// Ports
//   clock       system (oversampled) clock, rising edge
//   reset       asynchronous, active-high
//   in_data     signed 8-bit low-rate sample
//   in_valid    in_data valid this cycle
//   in_ready    FIFO can accept (transfer on in_valid && in_ready)
//   out_sample  signed interpolated sample, one per clock
//   out_valid   out_sample meaningful (set once RUN is entered)
//   underrun    sticky: FIFO was empty at a segment boundary
module interp_x16 #(
  parameter int FIFO_DEPTH = 4,
  parameter int RATIO_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_sample,
  output logic       out_valid,
  output logic       underrun
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ACCW = 8 + RATIO_LOG2;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          full, empty, push, pop;
  logic [7:0]    head;

  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  // Ready comes from the registered count only, so a pop in the same cycle
  // does not make room early. It is held low while reset is asserted.
  assign in_ready = !reset && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_q];

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= in_data;
  end

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t                state_q, state_d;
  logic [7:0]            prev_q, prev_d, next_q, next_d;
  logic [ACCW-1:0]       acc_q, acc_d;
  logic [RATIO_LOG2-1:0] k_q, k_d;
  logic                  unr_q, unr_d;
  logic                  seg_end;
  logic [8:0]            diff;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = PRIME;
      PRIME:   if (!empty) state_d = RUN;
      default: state_d = RUN;   // no way back out of RUN except reset
    endcase
  end

  always_comb begin
    seg_end    = (state_q == RUN) && (k_q == '1);
    pop        = !empty && ((state_q == IDLE) || (state_q == PRIME) || seg_end);
    out_valid  = (state_q == RUN);
    out_sample = (state_q == RUN) ? acc_q[ACCW-1 -: 8] : 8'd0;
    underrun   = unr_q;
  end

  // ---------------------------------------------------------------- datapath
  // The 9-bit difference is added every cycle. acc stays within
  // [16*min, 16*max] of the endpoints, so 12 bits never overflow. The top
  // byte of acc is the floored output.
  assign diff = {next_q[7], next_q} - {prev_q[7], prev_q};

  always_comb begin
    prev_d = prev_q;
    next_d = next_q;
    acc_d  = acc_q;
    k_d    = k_q;
    unr_d  = unr_q;
    case (state_q)
      IDLE: if (pop) prev_d = head;
      PRIME: if (pop) begin
        next_d = head;
        acc_d  = {prev_q, {RATIO_LOG2{1'b0}}};
        k_d    = '0;
      end
      default: begin
        if (seg_end) begin
          // Restart exactly on the endpoint, so segments join without a step.
          prev_d = next_q;
          acc_d  = {next_q, {RATIO_LOG2{1'b0}}};
          k_d    = '0;
          if (pop) next_d = head;
          else     unr_d  = 1'b1;   // next stays: diff becomes 0 and output holds
        end else begin
          k_d   = k_q + 1'b1;
          acc_d = acc_q + {{(ACCW-9){diff[8]}}, diff};
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      next_q <= '0;
      acc_q  <= '0;
      k_q    <= '0;
      unr_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      next_q <= next_d;
      acc_q  <= acc_d;
      k_q    <= k_d;
      unr_q  <= unr_d;
    end
  end

endmodule

// File: tb/tb_interp_x16.sv
// Directed bench for interp_x16: a per-cycle vector table for the 0/16 ramp
// (replayed after a mid-segment reset), plus hand-written sequences for floor
// rounding, extreme endpoints, FIFO back-pressure, and underrun.
module tb_interp_x16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_sample;
  logic       out_valid;
  logic       underrun;

  int nerr = 0;
  int nchk = 0;

  interp_x16 #(.FIFO_DEPTH(4), .RATIO_LOG2(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sample(out_sample),
    .out_valid (out_valid),
    .underrun  (underrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              vld;
    logic [7:0]        din;
    logic              rdy;
    logic              ov;
    logic signed [7:0] os;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, $signed(out_sample), 0);
    chk({tag, "_ov"},  {31'd0, out_valid}, 0);
    chk({tag, "_rdy"}, {31'd0, in_ready},  0);
    chk({tag, "_unr"}, {31'd0, underrun},  0);
  endtask

  // Called 1 time unit after an edge. Reset is asserted mid-cycle, so the
  // outputs must clear asynchronously, before the next edge.
  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    in_data  = 8'd0;
    #2 reset = 1'b1;
    #1 chk_zero(tag);
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;
    #1 chk({tag, "_rdy_rel"}, {31'd0, in_ready}, 1);
  endtask

  task automatic run_table(input string tag);
    for (int e = 0; e < 22; e++) begin
      in_valid = tbl[e].vld;
      in_data  = tbl[e].din;
      cyc();
      chk({tag, "_out"}, $signed(out_sample), tbl[e].os);
      chk({tag, "_ov"},  {31'd0, out_valid}, {31'd0, tbl[e].ov});
      chk({tag, "_rdy"}, {31'd0, in_ready},  {31'd0, tbl[e].rdy});
      chk({tag, "_unr"}, {31'd0, underrun},  0);
    end
    in_valid = 1'b0;
  endtask

  // Push a then b, then nothing. Every k of the segment is checked against
  // floor((16a + k(b-a))/16). The empty boundary that follows must hold b.
  task automatic pair_test(input string tag, input logic signed [7:0] a,
                           input logic signed [7:0] b);
    int ev;
    do_reset({tag, "_rst"});
    in_valid = 1'b1;
    in_data  = a;
    cyc();
    in_data  = b;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      ev = (16 * int'(a) + k * (int'(b) - int'(a))) >>> 4;
      chk({tag, "_k"}, $signed(out_sample), ev);
      chk({tag, "_ov"}, {31'd0, out_valid}, 1);
      chk({tag, "_unr_pre"}, {31'd0, underrun}, 0);
    end
    cyc();
    chk({tag, "_hold"}, $signed(out_sample), int'(b));
    chk({tag, "_unr"},  {31'd0, underrun}, 1);
  endtask

  initial begin
    int  nacc;
    logic rdy_b;

    // Ramp table: 0 then 16 continuously. Each row is the inputs before
    // edge e and the outputs expected just after it.
    for (int e = 0; e < 22; e++) begin
      tbl[e].vld = 1'b1;
      tbl[e].din = (e == 0) ? 8'd0 : 8'd16;
      tbl[e].ov  = (e >= 2);
      tbl[e].os  = (e < 2) ? 8'sd0 : ((e <= 18) ? 8'(e - 2) : 8'sd16);
      tbl[e].rdy = (e <= 4) || (e == 18);
    end

    #1;
    chk_zero("por");
    do_reset("rst0");
    run_table("ramp");

    pair_test("floor", 8'sd0, -8'sd1);
    pair_test("ext", 8'sd127, -8'sd128);

    // Back-pressure: in_valid held high. The FIFO fills to 4 after IDLE and
    // PRIME each pop one. Segment starts must then walk 10,20,30,... in order.
    do_reset("fill_rst");
    nacc     = 0;
    in_valid = 1'b1;
    in_data  = 8'd10;
    for (int e = 0; e < 86; e++) begin
      rdy_b = in_ready;
      cyc();
      if (rdy_b) begin
        nacc++;
        in_data = 8'(10 * (nacc + 1));
      end
      if (e == 5 || e == 17) begin
        chk("fill_rdy", {31'd0, in_ready}, 0);
        chk("fill_cnt", nacc, 6);
      end
      if (e >= 2 && ((e - 2) % 16) == 0)
        chk("fill_seg", $signed(out_sample), 10 * ((e - 2) / 16 + 1));
    end
    in_valid = 1'b0;

    // Underrun: three samples, a stall, then input resumes.
    do_reset("unr_rst");
    for (int e = 0; e < 52; e++) begin
      in_valid = (e <= 2) || (e == 41) || (e == 42);
      in_data  = (e == 0) ? 8'd0 : (e == 1) ? 8'd32 : (e == 2) ? 8'd64 : 8'd96;
      cyc();
      case (e)
        17: chk("unr_s1end", $signed(out_sample), 30);
        18: begin chk("unr_s2st", $signed(out_sample), 32); chk("unr_f18", {31'd0, underrun}, 0); end
        33: begin chk("unr_s2end", $signed(out_sample), 62); chk("unr_f33", {31'd0, underrun}, 0); end
        34: begin chk("unr_hold", $signed(out_sample), 64); chk("unr_f34", {31'd0, underrun}, 1); end
        40: begin chk("unr_hold2", $signed(out_sample), 64); chk("unr_f40", {31'd0, underrun}, 1); end
        50: chk("unr_res0", $signed(out_sample), 64);
        51: begin chk("unr_res1", $signed(out_sample), 66); chk("unr_f51", {31'd0, underrun}, 1); end
        default: ;
      endcase
    end
    in_valid = 1'b0;

    // Reset at k = 7, then replay the ramp: it must reproduce exactly.
    do_reset("mid_rst0");
    in_valid = 1'b1;
    for (int e = 0; e < 10; e++) begin
      in_data = (e == 0) ? 8'd0 : 8'd16;
      cyc();
    end
    chk("mid_k7", $signed(out_sample), 7);
    do_reset("mid_rst");
    run_table("replay");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/interp_x16.md
INTERP_X16 -- requirements
Module: interp_x16

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, input sample FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter RATIO_LOG2, fixed at 4, interpolation ratio 2^4 = 16 output samples per input sample.
REQ-003 SHALL have port clock  input  1  system (oversampled) clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  8  signed two's-complement low-rate sample.
REQ-006 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept; transfer on in_valid && in_ready at rising edge.
REQ-008 SHALL have port out_sample  output  8  signed interpolated sample, one per clock, drives modulator vin.
REQ-009 SHALL have port out_valid  output  1  out_sample meaningful.
REQ-010 SHALL have port underrun  output  1  sticky flag, FIFO empty at a segment boundary.

Function
REQ-011 SHALL store accepted samples in a FIFO_DEPTH-entry FIFO; in_ready = FIFO not full (registered count, no same-cycle pop pass-through).
REQ-012 SHALL make a sample pushed at edge N poppable at edge N+1 or later; push and pop in the same cycle SHALL both take effect.
REQ-013 SHALL implement states IDLE, PRIME, RUN; IDLE entered on reset.
REQ-014 IDLE: if FIFO non-empty, pop head into prev, go PRIME; out_valid = 0, out_sample = 0.
REQ-015 PRIME: if FIFO non-empty, pop head into next, load acc = prev*16, k = 0, go RUN, out_valid = 1 from the following cycle; else stay.
REQ-016 RUN: each cycle k increments, acc += (next - prev); diff is 9-bit signed, acc is 12-bit signed and SHALL never overflow.
REQ-017 out_sample SHALL equal acc[11:4], i.e. floor((16*prev + k*(next-prev))/16) (arithmetic, rounds toward minus infinity).
REQ-018 At k = 15 (segment end) SHALL set prev <= next, acc <= next*16, k <= 0, and if FIFO non-empty pop head into next.
REQ-019 At segment end with FIFO empty SHALL set next <= old next (diff 0, output holds), set underrun = 1, remain in RUN.
REQ-020 Output sequence SHALL be continuous: first output of each segment equals last segment's endpoint sample exactly.
REQ-021 underrun SHALL stay 1 until reset; it is not set in IDLE or PRIME.
REQ-022 Once in RUN, out_valid SHALL stay 1 until reset; there is no return to IDLE.
REQ-023 Steady-state throughput: one input sample consumed per 16 clocks; upstream SHALL be throttled only via in_ready.

Reset
REQ-024 While reset = 1: state IDLE, FIFO empty, prev = next = acc = k = 0, out_sample = 0, out_valid = 0, underrun = 0, in_ready = 0.
REQ-025 First cycle after reset deassertion in_ready SHALL be 1.
REQ-026 Reset asserted mid-segment SHALL discard FIFO contents and in-progress segment immediately (asynchronous).

Verification
REQ-027 Push 0 at edge 0, 16 at edge 1, 16 thereafter -> out_valid rises after edge 2; out_sample = 0,1,2,...,15,16,16,...
REQ-028 Push 0 then -1 -> out_sample = 0, then -1 for k = 1..15 (floor rounding check).
REQ-029 Push 127 then -128 -> k=0: 127, k=15: -113; no wrap to positive at any k.
REQ-030 Hold in_valid = 1 with no pops possible (IDLE, FIFO_DEPTH = 4 + 1 popped) -> in_ready drops after FIFO holds 4 entries; no sample lost or duplicated.
REQ-031 Supply 3 samples then stop -> after second segment boundary out_sample holds third sample, underrun = 1 and stays 1; resuming input restarts ramps, underrun still 1.
REQ-032 Assert reset at k = 7 of a segment -> all outputs 0 same cycle; after release, 0/16 stimulus of REQ-027 reproduces identical sequence.
